// File: rtl/top_cpu.sv
// UART-loaded 16-bit accumulator CPU with single-step / free-run execution.
// A program arrives as (opcode, operand) byte pairs and then runs from IMEM address 1.
module top_cpu #(
  parameter int CLKS_PER_BIT      = 868,
  parameter int IDLE_TIMEOUT_BITS = 20
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_rx,
  input  logic        ctrl_step_execution,
  input  logic        i_start_cpu,
  input  logic        i_next_instr_stimulus,
  input  logic        i_user_sample,
  output logic        o_instr_transmit_done,
  output logic [7:0]  o_max_addr,
  output logic        o_halt,
  output logic [15:0] o_alu_result_low,
  output logic [15:0] o_alu_result_high,
  output logic [4:0]  o_flags,
  output logic [7:0]  o_current_Opcode,
  output logic [7:0]  o_current_PC
);

  localparam int HALF_BIT    = CLKS_PER_BIT / 2;
  localparam int CNT_W       = $clog2(CLKS_PER_BIT);
  localparam int IDLE_CYCLES = CLKS_PER_BIT * IDLE_TIMEOUT_BITS;
  localparam int IDLE_W      = $clog2(IDLE_CYCLES + 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_FETCH, S_EXEC, S_WAIT_STEP, S_HALTED} cpu_state_e;

  logic             rx_meta_q, rx_sync_q;
  rx_state_e        rx_state_q, rx_state_d;
  logic [CNT_W-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]       rx_bit_q, rx_bit_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
  logic             rx_valid;

  logic [IDLE_W-1:0] idle_cnt_q, idle_cnt_d;
  logic              byte_phase_q, byte_phase_d;
  logic [7:0]        opcode_buf_q, opcode_buf_d;
  logic [7:0]        load_addr_q, load_addr_d;
  logic [7:0]        max_addr_q, max_addr_d;
  logic              have_instr_q, have_instr_d;
  logic              done_q, done_d;
  logic              imem_we;

  logic [15:0] imem_q [256];
  logic [15:0] dmem_q [256];
  logic        dmem_we;

  cpu_state_e  state_q, state_d;
  logic [7:0]  pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic [15:0] acc_q, acc_d;
  logic [15:0] mr_q, mr_d;
  logic [4:0]  flags_q, flags_d;
  logic        halt_q, halt_d;
  logic [7:0]  last_op_q, last_op_d;
  logic [7:0]  last_pc_q, last_pc_d;

  logic step_q, step_prev_q, step_edge;
  logic smp_q, smp_prev_q, smp_edge;
  logic [15:0] disp_low_q, disp_low_d, disp_high_q, disp_high_d;
  logic [4:0]  disp_flags_q, disp_flags_d;
  logic [7:0]  disp_op_q, disp_op_d, disp_pc_q, disp_pc_d;

  logic [15:0] alu_v, alu_acc, alu_mr, alu_diff;
  logic [16:0] alu_sum;
  logic [31:0] alu_prod;
  logic        alu_cf, alu_of, alu_mf, alu_upd, alu_jump, alu_store, alu_halt;
  logic [4:0]  alu_flags;

  assign step_edge = step_q & ~step_prev_q;
  assign smp_edge  = smp_q & ~smp_prev_q;

  // UART receiver: the first serial bit lands in the MSB of the received value.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_shift_d = rx_shift_q;
    rx_valid   = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (!rx_sync_q) begin
          rx_state_d = RX_START;
          rx_cnt_d   = '0;
        end
      end
      RX_START: begin
        if (rx_cnt_q == CNT_W'(HALF_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_bit_d   = '0;
          rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_cnt_d   = '0;
          rx_shift_d = {rx_shift_q[6:0], rx_sync_q};
          rx_bit_d   = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        if (rx_cnt_q == CNT_W'(CLKS_PER_BIT - 1)) begin
          rx_valid   = rx_sync_q;
          rx_state_d = RX_IDLE;
        end else begin
          rx_cnt_d = rx_cnt_q + 1'b1;
        end
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // Loader pairs bytes into instructions; a quiet line after at least one pair ends loading.
  always_comb begin
    idle_cnt_d   = idle_cnt_q;
    byte_phase_d = byte_phase_q;
    opcode_buf_d = opcode_buf_q;
    load_addr_d  = load_addr_q;
    max_addr_d   = max_addr_q;
    have_instr_d = have_instr_q;
    done_d       = done_q;
    imem_we      = 1'b0;
    if (!rx_sync_q || rx_state_q != RX_IDLE) begin
      idle_cnt_d = '0;
    end else if (idle_cnt_q != IDLE_W'(IDLE_CYCLES)) begin
      idle_cnt_d = idle_cnt_q + 1'b1;
    end
    if (!done_q) begin
      if (rx_valid) begin
        if (!byte_phase_q) begin
          opcode_buf_d = rx_shift_q;
          byte_phase_d = 1'b1;
        end else begin
          imem_we      = 1'b1;
          max_addr_d   = load_addr_q;
          load_addr_d  = load_addr_q + 8'd1;
          have_instr_d = 1'b1;
          byte_phase_d = 1'b0;
        end
      end
      if (have_instr_q && idle_cnt_q == IDLE_W'(IDLE_CYCLES)) done_d = 1'b1;
    end
  end

  always_comb begin
    alu_v     = ir_q[15] ? {8'h00, ir_q[7:0]} : dmem_q[ir_q[7:0]];
    alu_sum   = {1'b0, acc_q} + {1'b0, alu_v};
    alu_diff  = acc_q - alu_v;
    alu_prod  = {16'h0000, acc_q} * {16'h0000, alu_v};
    alu_acc   = acc_q;
    alu_mr    = mr_q;
    alu_cf    = 1'b0;
    alu_of    = 1'b0;
    alu_mf    = 1'b0;
    alu_upd   = 1'b0;
    alu_jump  = 1'b0;
    alu_store = 1'b0;
    alu_halt  = 1'b0;
    case (ir_q[11:8])
      4'h1: alu_store = 1'b1;
      4'h2: alu_acc = alu_v;
      4'h3: begin
        alu_acc = alu_sum[15:0];
        alu_cf  = alu_sum[16];
        alu_of  = (acc_q[15] == alu_v[15]) && (alu_sum[15] != acc_q[15]);
        alu_upd = 1'b1;
      end
      4'h4: begin
        alu_acc = alu_diff;
        alu_cf  = acc_q < alu_v;
        alu_of  = (acc_q[15] != alu_v[15]) && (alu_diff[15] != acc_q[15]);
        alu_upd = 1'b1;
      end
      4'h5: alu_jump = !acc_q[15] && (acc_q != 16'h0000);
      4'h6: alu_jump = 1'b1;
      4'h7: alu_halt = 1'b1;
      4'h8: begin
        alu_acc = alu_prod[15:0];
        alu_mr  = alu_prod[31:16];
        alu_mf  = |alu_prod[31:16];
        alu_upd = 1'b1;
      end
      4'h9: begin alu_acc = acc_q & alu_v;  alu_upd = 1'b1; end
      4'hA: begin alu_acc = acc_q | alu_v;  alu_upd = 1'b1; end
      4'hB: begin alu_acc = ~acc_q;         alu_upd = 1'b1; end
      4'hC: begin alu_acc = acc_q >> alu_v; alu_upd = 1'b1; end
      4'hD: begin alu_acc = acc_q << alu_v; alu_upd = 1'b1; end
      default: ;
    endcase
    alu_flags = alu_upd ? {alu_acc == 16'h0000, alu_cf, alu_of, alu_acc[15], alu_mf} : flags_q;
  end

  // Dropping i_start_cpu aborts a pending instruction without committing it.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    acc_d     = acc_q;
    mr_d      = mr_q;
    flags_d   = flags_q;
    halt_d    = halt_q;
    last_op_d = last_op_q;
    last_pc_d = last_pc_q;
    dmem_we   = 1'b0;
    case (state_q)
      S_LOAD: if (done_q) state_d = S_IDLE;
      S_IDLE: begin
        if (i_start_cpu) begin
          pc_d    = 8'd1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!i_start_cpu) begin
          state_d = S_IDLE;
        end else begin
          ir_d    = imem_q[pc_q];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (!i_start_cpu) begin
          state_d = S_IDLE;
        end else begin
          dmem_we   = alu_store;
          acc_d     = alu_acc;
          mr_d      = alu_mr;
          flags_d   = alu_flags;
          pc_d      = alu_jump ? ir_q[7:0] : pc_q + 8'd1;
          last_op_d = ir_q[15:8];
          last_pc_d = pc_q;
          if (alu_halt) begin
            halt_d  = 1'b1;
            state_d = S_HALTED;
          end else if (ctrl_step_execution) begin
            state_d = S_WAIT_STEP;
          end else begin
            state_d = S_FETCH;
          end
        end
      end
      S_WAIT_STEP: begin
        if (!i_start_cpu)   state_d = S_IDLE;
        else if (step_edge) state_d = S_FETCH;
      end
      S_HALTED: state_d = S_HALTED;
      default:  state_d = S_LOAD;
    endcase
  end

  always_comb begin
    disp_low_d   = disp_low_q;
    disp_high_d  = disp_high_q;
    disp_flags_d = disp_flags_q;
    disp_op_d    = disp_op_q;
    disp_pc_d    = disp_pc_q;
    if (smp_edge) begin
      disp_low_d   = acc_q;
      disp_high_d  = mr_q;
      disp_flags_d = flags_q;
      disp_op_d    = last_op_q;
      disp_pc_d    = last_pc_q;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta_q    <= 1'b1;
      rx_sync_q    <= 1'b1;
      rx_state_q   <= RX_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_shift_q   <= '0;
      idle_cnt_q   <= '0;
      byte_phase_q <= 1'b0;
      opcode_buf_q <= '0;
      load_addr_q  <= 8'd1;
      max_addr_q   <= '0;
      have_instr_q <= 1'b0;
      done_q       <= 1'b0;
      state_q      <= S_LOAD;
      pc_q         <= '0;
      ir_q         <= '0;
      acc_q        <= '0;
      mr_q         <= '0;
      flags_q      <= '0;
      halt_q       <= 1'b0;
      last_op_q    <= '0;
      last_pc_q    <= '0;
      step_q       <= 1'b0;
      step_prev_q  <= 1'b0;
      smp_q        <= 1'b0;
      smp_prev_q   <= 1'b0;
      disp_low_q   <= '0;
      disp_high_q  <= '0;
      disp_flags_q <= '0;
      disp_op_q    <= '0;
      disp_pc_q    <= '0;
    end else begin
      rx_meta_q    <= i_rx;
      rx_sync_q    <= rx_meta_q;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_shift_q   <= rx_shift_d;
      idle_cnt_q   <= idle_cnt_d;
      byte_phase_q <= byte_phase_d;
      opcode_buf_q <= opcode_buf_d;
      load_addr_q  <= load_addr_d;
      max_addr_q   <= max_addr_d;
      have_instr_q <= have_instr_d;
      done_q       <= done_d;
      state_q      <= state_d;
      pc_q         <= pc_d;
      ir_q         <= ir_d;
      acc_q        <= acc_d;
      mr_q         <= mr_d;
      flags_q      <= flags_d;
      halt_q       <= halt_d;
      last_op_q    <= last_op_d;
      last_pc_q    <= last_pc_d;
      step_q       <= i_next_instr_stimulus;
      step_prev_q  <= step_q;
      smp_q        <= i_user_sample;
      smp_prev_q   <= smp_q;
      disp_low_q   <= disp_low_d;
      disp_high_q  <= disp_high_d;
      disp_flags_q <= disp_flags_d;
      disp_op_q    <= disp_op_d;
      disp_pc_q    <= disp_pc_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (imem_we) imem_q[load_addr_q] <= {opcode_buf_q, rx_shift_q};
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 256; i++) dmem_q[i] <= '0;
    end else if (dmem_we) begin
      dmem_q[ir_q[7:0]] <= acc_q;
    end
  end

  assign o_instr_transmit_done = done_q;
  assign o_max_addr            = max_addr_q;
  assign o_halt                = halt_q;
  assign o_alu_result_low      = disp_low_q;
  assign o_alu_result_high     = disp_high_q;
  assign o_flags               = disp_flags_q;
  assign o_current_Opcode      = disp_op_q;
  assign o_current_PC          = disp_pc_q;

endmodule

// File: tb/tb_top_cpu.sv
// Directed bench for top_cpu: loads programs over UART (fast bit rate) and checks
// sampled registers in step and free-run modes, plus reset and reload behaviour.
module tb_top_cpu;

  localparam int CPB = 8;

  logic        clk = 1'b0;
  logic        i_rst_n;
  logic        i_rx;
  logic        ctrl_step_execution;
  logic        i_start_cpu;
  logic        i_next_instr_stimulus;
  logic        i_user_sample;
  logic        o_instr_transmit_done;
  logic [7:0]  o_max_addr;
  logic        o_halt;
  logic [15:0] o_alu_result_low;
  logic [15:0] o_alu_result_high;
  logic [4:0]  o_flags;
  logic [7:0]  o_current_Opcode;
  logic [7:0]  o_current_PC;

  int tests_run    = 0;
  int tests_failed = 0;
  logic [15:0] prog [$];

  top_cpu #(.CLKS_PER_BIT(CPB), .IDLE_TIMEOUT_BITS(20)) dut (
    .i_clk(clk),
    .i_rst_n(i_rst_n),
    .i_rx(i_rx),
    .ctrl_step_execution(ctrl_step_execution),
    .i_start_cpu(i_start_cpu),
    .i_next_instr_stimulus(i_next_instr_stimulus),
    .i_user_sample(i_user_sample),
    .o_instr_transmit_done(o_instr_transmit_done),
    .o_max_addr(o_max_addr),
    .o_halt(o_halt),
    .o_alu_result_low(o_alu_result_low),
    .o_alu_result_high(o_alu_result_high),
    .o_flags(o_flags),
    .o_current_Opcode(o_current_Opcode),
    .o_current_PC(o_current_PC)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    i_rst_n = 1'b0;
    i_start_cpu = 1'b0;
    ctrl_step_execution = 1'b0;
    i_next_instr_stimulus = 1'b0;
    i_user_sample = 1'b0;
    i_rx = 1'b1;
    repeat (4) @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // The first bit on the wire is the MSB of the instruction byte.
  task automatic send_byte(input logic [7:0] v);
    i_rx = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 7; i >= 0; i--) begin
      i_rx = v[i];
      repeat (CPB) @(negedge clk);
    end
    i_rx = 1'b1;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic send_program();
    foreach (prog[i]) begin
      send_byte(prog[i][15:8]);
      send_byte(prog[i][7:0]);
    end
  endtask

  task automatic wait_done();
    for (int i = 0; i < 1000 && !o_instr_transmit_done; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_halt();
    for (int i = 0; i < 3000 && !o_halt; i++) @(negedge clk);
    repeat (2) @(negedge clk);
  endtask

  task automatic pulse_step();
    i_next_instr_stimulus = 1'b1;
    @(negedge clk);
    i_next_instr_stimulus = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  task automatic take_sample();
    i_user_sample = 1'b1;
    @(negedge clk);
    i_user_sample = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++;
    if ({o_instr_transmit_done, o_max_addr, o_halt} !== 10'h000) begin
      tests_failed++;
      $display("[TB] FAIL reset_status: got %h expected 000", {o_instr_transmit_done, o_max_addr, o_halt});
    end
    tests_run++;
    if ({o_alu_result_low, o_alu_result_high} !== 32'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_regs: got %h expected 0", {o_alu_result_low, o_alu_result_high});
    end
    tests_run++;
    if ({o_flags, o_current_Opcode, o_current_PC} !== 21'h0) begin
      tests_failed++;
      $display("[TB] FAIL reset_disp: got %h expected 0", {o_flags, o_current_Opcode, o_current_PC});
    end
  endtask

  task automatic test_multiply();
    prog = '{16'h82FF, 16'h88FE, 16'h8101, 16'h82FF, 16'h0801,
             16'h8103, 16'h0203, 16'h0204, 16'h0700};
    send_program();
    wait_done();
    tests_run++;
    if (o_instr_transmit_done !== 1'b1 || o_max_addr !== 8'd9) begin
      tests_failed++;
      $display("[TB] FAIL mpy_load: got done=%b max=%h expected done=1 max=09", o_instr_transmit_done, o_max_addr);
    end
    ctrl_step_execution = 1'b1;
    i_start_cpu = 1'b1;
    repeat (12) @(negedge clk);
    take_sample();
    tests_run++;
    if (o_current_PC !== 8'd1 || o_alu_result_low !== 16'h00FF) begin
      tests_failed++;
      $display("[TB] FAIL mpy_first_auto: got pc=%h acc=%h expected pc=01 acc=00ff", o_current_PC, o_alu_result_low);
    end
    pulse_step();
    take_sample();
    tests_run++;
    if ({o_alu_result_high, o_alu_result_low, o_flags} !== {16'h0000, 16'hFD02, 5'b00010}) begin
      tests_failed++;
      $display("[TB] FAIL mpy_imm: got mr=%h acc=%h f=%b expected mr=0000 acc=fd02 f=00010",
               o_alu_result_high, o_alu_result_low, o_flags);
    end
    repeat (3) pulse_step();
    take_sample();
    tests_run++;
    if ({o_alu_result_high, o_alu_result_low, o_flags, o_current_Opcode, o_current_PC} !==
        {16'h00FC, 16'h04FE, 5'b00001, 8'h08, 8'h05}) begin
      tests_failed++;
      $display("[TB] FAIL mpy_addr5: got mr=%h acc=%h f=%b op=%h pc=%h expected 00fc 04fe 00001 08 05",
               o_alu_result_high, o_alu_result_low, o_flags, o_current_Opcode, o_current_PC);
    end
  endtask

  task automatic test_stepping();
    i_next_instr_stimulus = 1'b1;
    repeat (5) @(negedge clk);
    i_next_instr_stimulus = 1'b0;
    repeat (12) @(negedge clk);
    take_sample();
    tests_run++;
    if (o_current_PC !== 8'd6 || o_current_Opcode !== 8'h81) begin
      tests_failed++;
      $display("[TB] FAIL step_held: got pc=%h op=%h expected pc=06 op=81", o_current_PC, o_current_Opcode);
    end
    repeat (20) @(negedge clk);
    take_sample();
    tests_run++;
    if (o_current_PC !== 8'd6 || o_alu_result_low !== 16'h04FE) begin
      tests_failed++;
      $display("[TB] FAIL step_no_edge: got pc=%h acc=%h expected pc=06 acc=04fe", o_current_PC, o_alu_result_low);
    end
    repeat (3) pulse_step();
    tests_run++;
    if (o_halt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL step_halt: got %b expected 1", o_halt);
    end
    take_sample();
    tests_run++;
    if ({o_alu_result_low, o_alu_result_high, o_flags, o_current_Opcode, o_current_PC} !==
        {16'h0000, 16'h00FC, 5'b00001, 8'h07, 8'h09}) begin
      tests_failed++;
      $display("[TB] FAIL step_final: got acc=%h mr=%h f=%b op=%h pc=%h expected 0000 00fc 00001 07 09",
               o_alu_result_low, o_alu_result_high, o_flags, o_current_Opcode, o_current_PC);
    end
  endtask

  task automatic test_logic_jump();
    do_reset();
    prog = '{16'h8264, 16'h0101, 16'h8263, 16'h0401, 16'h890C, 16'h8A03,
             16'h8102, 16'h0B02, 16'h860B, 16'h8301, 16'h0700};
    send_program();
    wait_done();
    send_byte(8'h07);
    send_byte(8'h00);
    repeat (20) @(negedge clk);
    tests_run++;
    if (o_instr_transmit_done !== 1'b1 || o_max_addr !== 8'd11) begin
      tests_failed++;
      $display("[TB] FAIL lj_load: got done=%b max=%h expected done=1 max=0b", o_instr_transmit_done, o_max_addr);
    end
    ctrl_step_execution = 1'b1;
    i_start_cpu = 1'b1;
    repeat (12) @(negedge clk);
    repeat (3) pulse_step();
    take_sample();
    tests_run++;
    if ({o_alu_result_low, o_flags} !== {16'hFFFF, 5'b01010}) begin
      tests_failed++;
      $display("[TB] FAIL lj_sub: got acc=%h f=%b expected ffff 01010", o_alu_result_low, o_flags);
    end
    ctrl_step_execution = 1'b0;
    pulse_step();
    wait_halt();
    take_sample();
    tests_run++;
    if ({o_halt, o_alu_result_low, o_flags, o_current_PC} !== {1'b1, 16'hFFF0, 5'b00010, 8'd11}) begin
      tests_failed++;
      $display("[TB] FAIL lj_final: got halt=%b acc=%h f=%b pc=%h expected 1 fff0 00010 0b",
               o_halt, o_alu_result_low, o_flags, o_current_PC);
    end
  endtask

  task automatic test_shift();
    do_reset();
    prog = '{16'h8201, 16'h8D0F, 16'h8C0A, 16'h8101, 16'h8D0B,
             16'h8102, 16'h0201, 16'h0202, 16'h0700};
    send_program();
    wait_done();
    ctrl_step_execution = 1'b1;
    i_start_cpu = 1'b1;
    repeat (12) @(negedge clk);
    repeat (6) pulse_step();
    take_sample();
    tests_run++;
    if (o_alu_result_low !== 16'h0020 || o_current_PC !== 8'd7) begin
      tests_failed++;
      $display("[TB] FAIL shift_dmem1: got acc=%h pc=%h expected 0020 07", o_alu_result_low, o_current_PC);
    end
    ctrl_step_execution = 1'b0;
    pulse_step();
    wait_halt();
    take_sample();
    tests_run++;
    if ({o_halt, o_alu_result_low, o_flags, o_current_PC} !== {1'b1, 16'h0000, 5'b10000, 8'd9}) begin
      tests_failed++;
      $display("[TB] FAIL shift_final: got halt=%b acc=%h f=%b pc=%h expected 1 0000 10000 09",
               o_halt, o_alu_result_low, o_flags, o_current_PC);
    end
  endtask

  task automatic test_loop();
    do_reset();
    prog = '{16'h8200, 16'h8110, 16'h8203, 16'h8111, 16'h0210, 16'h8301, 16'h8110,
             16'h0211, 16'h8401, 16'h8111, 16'h8505, 16'h0210, 16'h8405, 16'h8501, 16'h0700};
    send_program();
    wait_done();
    ctrl_step_execution = 1'b0;
    i_start_cpu = 1'b1;
    wait_halt();
    take_sample();
    tests_run++;
    if (o_halt !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL loop_halt: got %b expected 1", o_halt);
    end
    tests_run++;
    if ({o_alu_result_low, o_flags, o_current_Opcode, o_current_PC} !== {16'hFFFE, 5'b01010, 8'h07, 8'd15}) begin
      tests_failed++;
      $display("[TB] FAIL loop_final: got acc=%h f=%b op=%h pc=%h expected fffe 01010 07 0f",
               o_alu_result_low, o_flags, o_current_Opcode, o_current_PC);
    end
  endtask

  task automatic test_reset_reload();
    @(negedge clk);
    i_rst_n = 1'b0;
    i_start_cpu = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({o_halt, o_instr_transmit_done, o_max_addr} !== 10'h000) begin
      tests_failed++;
      $display("[TB] FAIL rr_clear_status: got %h expected 000", {o_halt, o_instr_transmit_done, o_max_addr});
    end
    tests_run++;
    if ({o_alu_result_low, o_flags, o_current_PC} !== 29'h0) begin
      tests_failed++;
      $display("[TB] FAIL rr_clear_disp: got %h expected 0", {o_alu_result_low, o_flags, o_current_PC});
    end
    i_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    prog = '{16'h8200};
    send_program();
    wait_done();
    tests_run++;
    if (o_instr_transmit_done !== 1'b1 || o_max_addr !== 8'd1) begin
      tests_failed++;
      $display("[TB] FAIL rr_reload: got done=%b max=%h expected done=1 max=01", o_instr_transmit_done, o_max_addr);
    end
  endtask

  initial begin
    i_rst_n = 1'b0;
    i_rx = 1'b1;
    ctrl_step_execution = 1'b0;
    i_start_cpu = 1'b0;
    i_next_instr_stimulus = 1'b0;
    i_user_sample = 1'b0;
    test_reset();
    test_multiply();
    test_stepping();
    test_logic_jump();
    test_shift();
    test_loop();
    test_reset_reload();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
